// File: rtl/team_06_noise_gate_if.sv
// ---------------------------------------------------------------------------
// team_06_noise_gate_if
// Purpose : bundles the sample stream into and out of the noise gate.
// Signals : en           - gate enable from the FSM noise_gate_tog (0 = bypass)
//           sample_valid - one-cycle strobe, audio_in carries a new sample
//           audio_in     - unsigned offset-binary mic sample, 128 = silence
//           audio_out    - gated sample, held between strobes
//           out_valid    - one-cycle strobe, audio_out was just updated
//           gate_open    - high whenever the gate is not CLOSED
//           gate_state   - CLOSED=0, OPEN=1, HOLD=2, RELEASE=3
// Modports: master drives the sample stream, slave is the gate itself.
// ---------------------------------------------------------------------------
interface team_06_noise_gate_if;
  logic       en;
  logic       sample_valid;
  logic [7:0] audio_in;
  logic [7:0] audio_out;
  logic       out_valid;
  logic       gate_open;
  logic [1:0] gate_state;

  modport master (
    output en, sample_valid, audio_in,
    input  audio_out, out_valid, gate_open, gate_state
  );

  modport slave (
    input  en, sample_valid, audio_in,
    output audio_out, out_valid, gate_open, gate_state
  );
endinterface

// File: rtl/team_06_noise_gate.sv
// ---------------------------------------------------------------------------
// team_06_noise_gate
// Purpose : mutes low-level mic noise with a four-state gate (CLOSED, OPEN,
//           HOLD, RELEASE). Opening needs ATTACK_SAMPLES consecutive loud
//           samples, closing waits HOLD_SAMPLES quiet samples and then fades
//           out in halving steps of RELEASE_SAMPLES samples each.
//           Every sample is processed on its strobe with one cycle of
//           registered latency.
// Ports   : clk - system clock
//           rst - asynchronous active-low reset
//           bus - team_06_noise_gate_if slave (see interface header)
// ---------------------------------------------------------------------------
module team_06_noise_gate #(
  parameter int THRESH          = 16,
  parameter int ATTACK_SAMPLES  = 2,
  parameter int HOLD_SAMPLES    = 4,
  parameter int RELEASE_SAMPLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  team_06_noise_gate_if.slave  bus
);

  localparam logic [7:0] THRESH_N  = 8'(THRESH);
  localparam logic [7:0] ATTACK_N  = 8'(ATTACK_SAMPLES);
  localparam logic [7:0] HOLD_N    = 8'(HOLD_SAMPLES);
  localparam logic [7:0] RELEASE_N = 8'(RELEASE_SAMPLES);
  localparam logic [7:0] SILENCE   = 8'd128;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPEN    = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } gate_state_e;

  gate_state_e state_q, state_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [2:0]  shift_q, shift_d;
  logic [7:0]  audio_out_q, audio_out_d;
  logic        out_valid_q;

  logic        positive;
  logic [7:0]  mag;
  logic        loud;
  logic [7:0]  mag_shifted;
  logic [8:0]  att_sum;
  logic [7:0]  attenuated;

  // Distance from the 128 midpoint; audio_in=0 gives 128, which still fits.
  // The attenuated sample keeps the original polarity around 128.
  always_comb begin
    positive    = bus.audio_in[7];
    mag         = positive ? (bus.audio_in - SILENCE) : (SILENCE - bus.audio_in);
    loud        = (mag >= THRESH_N);
    mag_shifted = mag >> shift_q;
    att_sum     = {1'b0, SILENCE} + {1'b0, mag_shifted};
    if (positive) begin
      attenuated = att_sum[8] ? 8'd255 : att_sum[7:0];
    end else begin
      attenuated = SILENCE - mag_shifted;
    end
  end

  // Next-state logic. The output for a sample is chosen from the state held
  // before that sample; any transition only affects the following sample.
  // A low enable parks everything in CLOSED on every clock, strobe or not.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    hcnt_d      = hcnt_q;
    rcnt_d      = rcnt_q;
    shift_d     = shift_q;
    audio_out_d = audio_out_q;

    if (!bus.en) begin
      state_d = CLOSED;
      run_d   = '0;
      hcnt_d  = '0;
      rcnt_d  = '0;
      shift_d = '0;
      if (bus.sample_valid) begin
        audio_out_d = bus.audio_in;
      end
    end else if (bus.sample_valid) begin
      unique case (state_q)
        CLOSED: begin
          audio_out_d = SILENCE;
          if (loud) begin
            if (run_q + 8'd1 == ATTACK_N) begin
              state_d = OPEN;
              run_d   = '0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end else begin
            run_d = '0;
          end
        end

        OPEN: begin
          audio_out_d = bus.audio_in;
          if (!loud) begin
            hcnt_d = 8'd1;
            // A one-sample hold goes straight into the first fade step.
            if (HOLD_N == 8'd1) begin
              state_d = RELEASE;
              shift_d = 3'd1;
              rcnt_d  = '0;
            end else begin
              state_d = HOLD;
            end
          end
        end

        HOLD: begin
          audio_out_d = bus.audio_in;
          if (loud) begin
            state_d = OPEN;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
            if (hcnt_q + 8'd1 == HOLD_N) begin
              state_d = RELEASE;
              shift_d = 3'd1;
              rcnt_d  = '0;
            end
          end
        end

        RELEASE: begin
          audio_out_d = attenuated;
          if (loud) begin
            state_d = OPEN;
            shift_d = '0;
            rcnt_d  = '0;
          end else if (rcnt_q + 8'd1 == RELEASE_N) begin
            rcnt_d = '0;
            // Step past shift 7 means the fade is finished.
            if (shift_q == 3'd7) begin
              state_d = CLOSED;
              shift_d = '0;
            end else begin
              shift_d = shift_q + 3'd1;
            end
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end

        default: begin
          state_d = CLOSED;
        end
      endcase
    end
  end

  // State and output registers; out_valid is the strobe delayed one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLOSED;
      run_q       <= '0;
      hcnt_q      <= '0;
      rcnt_q      <= '0;
      shift_q     <= '0;
      audio_out_q <= SILENCE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      hcnt_q      <= hcnt_d;
      rcnt_q      <= rcnt_d;
      shift_q     <= shift_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= bus.sample_valid;
    end
  end

  assign bus.audio_out  = audio_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.gate_open  = (state_q != CLOSED);
  assign bus.gate_state = state_q;

endmodule

// File: tb/tb_team_06_noise_gate.sv
// ---------------------------------------------------------------------------
// tb_team_06_noise_gate
// Purpose : directed test of team_06_noise_gate. A behavioural model follows
//           the gate as "open or not" plus a count of consecutive quiet
//           samples since the last loud one; hold and fade step are derived
//           from that count. A negedge process compares every cycle, and
//           literal expectations pin the model on the key sequences.
// ---------------------------------------------------------------------------
module tb_team_06_noise_gate;

  localparam int TH = 16;
  localparam int AT = 2;
  localparam int HO = 4;
  localparam int RE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  team_06_noise_gate_if bus ();

  team_06_noise_gate #(
    .THRESH(TH), .ATTACK_SAMPLES(AT), .HOLD_SAMPLES(HO), .RELEASE_SAMPLES(RE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit checkOn    = 1'b0;

  bit         mOpen;
  int         mLoudRun;
  int         mQuiet;
  logic [7:0] expAudio;
  logic       expValid;

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int magOf(input logic [7:0] d);
    return (d >= 8'd128) ? int'(d) - 128 : 128 - int'(d);
  endfunction

  // What an enabled gate emits for sample d given the model's current view.
  function automatic logic [7:0] modelOut(input logic [7:0] d);
    int lvl;
    int m;
    if (!mOpen) return 8'd128;
    if (mQuiet < HO) return d;
    lvl = 1 + (mQuiet - HO) / RE;
    m   = magOf(d) >> lvl;
    return (d >= 8'd128) ? 8'(128 + m) : 8'(128 - m);
  endfunction

  function automatic logic [1:0] modelState();
    if (!mOpen) return 2'd0;
    if (mQuiet == 0) return 2'd1;
    if (mQuiet < HO) return 2'd2;
    return 2'd3;
  endfunction

  task automatic modelReset();
    mOpen    = 1'b0;
    mLoudRun = 0;
    mQuiet   = 0;
    expAudio = 8'd128;
    expValid = 1'b0;
  endtask

  task automatic modelStep(input bit e, input bit v, input logic [7:0] d);
    bit loud;
    expValid = v;
    if (!e) begin
      if (v) expAudio = d;
      mOpen    = 1'b0;
      mLoudRun = 0;
      mQuiet   = 0;
    end else if (v) begin
      loud     = (magOf(d) >= TH);
      expAudio = modelOut(d);
      if (mOpen) begin
        if (loud) mQuiet = 0;
        else begin
          mQuiet++;
          if (mQuiet == HO + 7 * RE) begin
            mOpen  = 1'b0;
            mQuiet = 0;
          end
        end
      end else begin
        if (loud) begin
          mLoudRun++;
          if (mLoudRun == AT) begin
            mOpen    = 1'b1;
            mLoudRun = 0;
          end
        end else begin
          mLoudRun = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, let the clock edge take it, then advance the model.
  task automatic applyStimulus(input bit e, input bit v, input logic [7:0] d);
    bus.en           = e;
    bus.sample_valid = v;
    bus.audio_in     = d;
    @(posedge clk);
    #1;
    modelStep(e, v, d);
  endtask

  // Compare every output against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model audio_out", {8'd0, bus.audio_out}, {8'd0, expAudio});
      checkOutput("model out_valid", {15'd0, bus.out_valid}, {15'd0, expValid});
      checkOutput("model gate_open", {15'd0, bus.gate_open}, {15'd0, mOpen});
      checkOutput("model gate_state", {14'd0, bus.gate_state}, {14'd0, modelState()});
    end
  end

  logic [7:0] relExp [14];
  logic [7:0] mixVals [12];

  initial begin
    relExp = '{8'd134, 8'd134, 8'd131, 8'd131, 8'd129, 8'd129, 8'd128,
               8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    mixVals = '{8'd128, 8'd150, 8'd100, 8'd140, 8'd143, 8'd144,
                8'd112, 8'd255, 8'd0, 8'd129, 8'd200, 8'd60};

    bus.en           = 1'b0;
    bus.sample_valid = 1'b0;
    bus.audio_in     = 8'd128;
    modelReset();
    #1;
    checkOn = 1'b1;
    repeat (2) @(posedge clk);
    checkOutput("reset audio_out", {8'd0, bus.audio_out}, 16'd128);
    checkOutput("reset out_valid", {15'd0, bus.out_valid}, 16'd0);
    #1;
    rst = 1'b1;

    // Bypass
    applyStimulus(1'b0, 1'b1, 8'd37);
    checkOutput("bypass audio_out", {8'd0, bus.audio_out}, 16'd37);
    checkOutput("bypass out_valid", {15'd0, bus.out_valid}, 16'd1);
    checkOutput("bypass gate_state", {14'd0, bus.gate_state}, 16'd0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("bypass hold audio_out", {8'd0, bus.audio_out}, 16'd37);
    checkOutput("bypass strobe drops", {15'd0, bus.out_valid}, 16'd0);

    // Attack
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("attack1 audio_out", {8'd0, bus.audio_out}, 16'd128);
    checkOutput("attack1 gate_open", {15'd0, bus.gate_open}, 16'd0);
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("attack2 audio_out", {8'd0, bus.audio_out}, 16'd128);
    checkOutput("attack2 gate_open", {15'd0, bus.gate_open}, 16'd1);
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("attack3 audio_out", {8'd0, bus.audio_out}, 16'd150);

    // Hold then full release fade
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'd140);
      checkOutput("hold audio_out", {8'd0, bus.audio_out}, 16'd140);
    end
    checkOutput("hold ends in release", {14'd0, bus.gate_state}, 16'd3);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b1, 8'd140);
      checkOutput("release fade", {8'd0, bus.audio_out}, {8'd0, relExp[i]});
    end
    checkOutput("release closes", {14'd0, bus.gate_state}, 16'd0);
    applyStimulus(1'b1, 1'b1, 8'd140);
    checkOutput("closed after fade", {8'd0, bus.audio_out}, 16'd128);

    // Interrupted attack clears the run
    applyStimulus(1'b1, 1'b1, 8'd150);
    applyStimulus(1'b1, 1'b1, 8'd130);
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("run cleared audio_out", {8'd0, bus.audio_out}, 16'd128);
    checkOutput("run cleared gate_open", {15'd0, bus.gate_open}, 16'd0);
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("reattack opens", {14'd0, bus.gate_state}, 16'd1);

    // Retrigger from the first fade step
    repeat (4) applyStimulus(1'b1, 1'b1, 8'd140);
    applyStimulus(1'b1, 1'b1, 8'd100);
    checkOutput("retrigger attenuated", {8'd0, bus.audio_out}, 16'd114);
    applyStimulus(1'b1, 1'b1, 8'd100);
    checkOutput("retrigger open", {8'd0, bus.audio_out}, 16'd100);

    // Threshold boundaries
    applyStimulus(1'b1, 1'b1, 8'd143);
    checkOutput("mag15 is quiet", {14'd0, bus.gate_state}, 16'd2);
    applyStimulus(1'b1, 1'b1, 8'd144);
    checkOutput("mag16 high is loud", {14'd0, bus.gate_state}, 16'd1);
    applyStimulus(1'b1, 1'b1, 8'd143);
    applyStimulus(1'b1, 1'b1, 8'd112);
    checkOutput("mag16 low is loud", {14'd0, bus.gate_state}, 16'd1);

    // Enable drop
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("enable drop closes", {14'd0, bus.gate_state}, 16'd0);
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("enable return muted", {8'd0, bus.audio_out}, 16'd128);

    // Reset in the middle of a release
    applyStimulus(1'b1, 1'b1, 8'd150);
    repeat (5) applyStimulus(1'b1, 1'b1, 8'd140);
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset audio_out", {8'd0, bus.audio_out}, 16'd128);
    checkOutput("midreset out_valid", {15'd0, bus.out_valid}, 16'd0);
    checkOutput("midreset gate_open", {15'd0, bus.gate_open}, 16'd0);
    checkOutput("midreset gate_state", {14'd0, bus.gate_state}, 16'd0);
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'd150);
    checkOutput("after reset closed", {8'd0, bus.audio_out}, 16'd128);

    // Mixed traffic with gaps and enable glitches, checked by the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus((i % 17) != 5, (i % 3) != 2, mixVals[(i * 7) % 12]);
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b1, mixVals[(i % 2 == 0) ? 1 : 4]);
    end

    applyStimulus(1'b1, 1'b0, 8'd128);
    checkOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/team_06_noise_gate.md
Name: team_06_noise_gate

Overview:
- Downstream audio stage fed by team_06_FSM: consumes the mic sample stream and the FSM's noise_gate_tog level; emits gated audio toward the effect/volume path.
- Mutes low-level mic noise using a 4-state gate: attack qualification, hold, then stepped release fade.
- All processing is paced by a per-sample strobe, with 1-cycle registered latency.

Parameters:
- THRESH, 16, magnitude at or above which a sample is "loud" (1..127)
- ATTACK_SAMPLES, 2, consecutive loud samples needed to open (1..255)
- HOLD_SAMPLES, 4, consecutive quiet samples before release begins (1..255)
- RELEASE_SAMPLES, 2, samples spent at each attenuation step (1..255)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  gate enable, driven from FSM noise_gate_tog; 0 = bypass
- sample_valid  input  1  one-cycle strobe, new audio_in sample
- audio_in  input  8  unsigned offset-binary mic sample; 128 = silence
- audio_out  output  8  gated sample
- out_valid  output  1  one-cycle strobe, audio_out updated
- gate_open  output  1  1 when state != CLOSED
- gate_state  output  2  CLOSED=0, OPEN=1, HOLD=2, RELEASE=3

Behaviour:
- Reset (rst low, async): audio_out=128, out_valid=0, state=CLOSED, all counters=0, shift=0.
- Magnitude: mag = audio_in>=128 ? audio_in-128 : 128-audio_in (0..128). loud = mag>=THRESH.
- Work happens only in cycles with sample_valid=1. out_valid is sample_valid delayed 1 cycle. audio_out is registered and holds its value between strobes.
- Output is chosen by the registered state before the sample's update. A decision takes effect from the next sample.
- en=0 at a strobe: audio_out=audio_in. Independently of strobes, on any clock with en=0 the block forces state=CLOSED and clears run/hcnt/rcnt/shift.
- en rising: the gate starts in CLOSED.
- CLOSED:
  - Output 128.
  - Loud sample: run+1; if run+1==ATTACK_SAMPLES, go OPEN and run=0.
  - Quiet sample: run=0.
- OPEN:
  - Output audio_in.
  - Quiet sample: hcnt=1; next state is RELEASE if HOLD_SAMPLES==1, else HOLD.
  - Loud sample: stay.
- HOLD:
  - Output audio_in.
  - Loud sample: go OPEN, hcnt=0.
  - Quiet sample: hcnt+1; if it equals HOLD_SAMPLES, go RELEASE with shift=1, rcnt=0.
- RELEASE:
  - Output 128+(mag>>shift) if audio_in>=128, else 128-(mag>>shift).
  - Loud sample: go OPEN, shift=0, rcnt=0.
  - Quiet sample: rcnt+1. When it equals RELEASE_SAMPLES, rcnt=0 and shift+1. When shift would pass 7, go CLOSED.
  - Total release length is 7*RELEASE_SAMPLES quiet samples.
- Arithmetic: the output cannot overflow (max 128+128 clamps to 255; the 128+128 case only arises in bypass/OPEN pass-through, which is a direct copy).
- sample_valid held high on consecutive cycles: every cycle is a new sample, with no throughput loss.
- Reset mid-release/attack: immediate return to reset values; the next sample is treated as CLOSED.

Test Plan:
- Reset: assert rst=0 mid-stream -> same cycle audio_out=128, out_valid=0, gate_open=0, gate_state=0.
- Bypass: en=0, strobe audio_in=37 -> next cycle audio_out=37, out_valid=1, gate_state=0.
- Attack: en=1, strobes 150,150,150 -> audio_out 128,128,150; gate_open rises after the 2nd strobe. Also strobes 150,130,150 -> 128,128,128 (run cleared).
- Hold/release: open the gate, then 140 x4 -> 140 x4. Then 140 x14 -> 134,134,131,131,129,129,128... (mag 12>>1..7). gate_state=0 after the 14th; the next sample outputs 128.
- Retrigger and threshold: in RELEASE shift=1, strobe 100 -> 114, next 100 -> 100 (OPEN). Boundaries: 143 (mag 15) quiet, 144 and 112 (mag 16) loud.
- Enable drop: in OPEN, en=0 for one cycle then 1 -> gate_state=0; strobe 150 outputs 128.
